led_meter_sched: RTL and testbench
==================================

# led_meter_sched

Round-robin scheduler that shares one LED level-meter datapath among several 12-bit offset-binary sample sources, with zero at 12'h800. Each source deposits samples into a one-deep holding register. The scheduler grants one pending source at a time, drives the meter's `VALUE` bus, and forms a clean `SAMPLE_TR` strobe with guaranteed setup, high and low widths. `CH_SEL` tells the display mux which channel the meter currently reflects.

## Interface
- `NCH`, default 4: number of requesting channels, 2..8.
- `PULSE_W`, default 4: `SAMPLE_TR` high time in `CLK` cycles, ≥1.
- `GAP_W`, default 4: minimum `SAMPLE_TR` low time after each pulse, ≥1.
- `CLK` in 1: single clock for the block; every flop is on its rising edge.
- `RESET_n` in 1: asynchronous assert, active-low reset.
- `IN_VALID` in NCH: per-channel one-cycle sample strobe.
- `IN_DATA` in 12*NCH: channel k occupies bits [12k+11:12k].
- `ENABLE` in 1: permits new grants.
- `OVR_CLR` in 1: one-cycle clear of all `OVR` bits.
- `VALUE` out 12: sample presented to the meter.
- `SAMPLE_TR` out 1: meter sample strobe; the meter captures on its rising edge.
- `CH_SEL` out 3: channel owning `VALUE`; bits above clog2(NCH) are 0.
- `OVR` out NCH: sticky per-channel overrun flags.
- `BUSY` out 1: high in any state other than IDLE.

## Operation
- Each channel has a 12-bit holding register `hold[k]` and a `pend[k]` flag.
- **Capture:** `IN_VALID[k]=1` loads `IN_DATA[k]` into `hold[k]` and sets `pend[k]`.
- **Overrun:** if `pend[k]` is already set and the pending sample is not consumed this cycle, the old sample is overwritten and `OVR[k]` is set.
- **FSM states:** IDLE → SETUP → HIGH → LOW → IDLE.
- **IDLE:**
  - If `ENABLE=1` and any `pend` bit is set, grant the first pending channel searching upward from `last+1`, modulo NCH.
  - At the exit edge, the grant loads `VALUE ← hold[g]`, `CH_SEL ← g` and `last ← g`, clears `pend[g]`, and moves to SETUP.
  - Otherwise stay in IDLE.
- **SETUP:** one cycle; `SAMPLE_TR=0` and `VALUE` is stable.
- **HIGH:** `SAMPLE_TR=1` for exactly `PULSE_W` cycles.
- **LOW:** `SAMPLE_TR=0` for exactly `GAP_W` cycles, then IDLE.
- `VALUE` and `CH_SEL` hold from SETUP entry until the next grant, so the display continues to show the last channel.
- **Simultaneous events:**
  - Grant of channel k together with `IN_VALID[k]` in the same cycle: the old sample goes to `VALUE`, the new sample lands in `hold[k]`, `pend[k]` stays 1, and there is no overrun.
  - `OVR_CLR` together with a new overrun on the same channel: set wins.
- **ENABLE low** mid-transaction: the current SETUP/HIGH/LOW sequence completes and the block then parks in IDLE. Captures and overrun tracking continue.
- **Reset mid-operation:** all state and outputs return to reset values immediately, asynchronously; `SAMPLE_TR` drops without completing its pulse.
- **`last` pointer:** resets to NCH-1, so the first grant after reset goes to the lowest-numbered pending channel, starting from channel 0.

## Timing
- **Reset values:** `VALUE=12'h800`, `SAMPLE_TR=0`, `CH_SEL=0`, `OVR=0`, `BUSY=0`, all `pend=0`, FSM in IDLE.
- **Capture to grant:** `IN_VALID` at edge t sets `pend` at t. Earliest grant edge is t+1 if the FSM is idle.
- **`VALUE` setup:** `VALUE` changes exactly 1 cycle before the `SAMPLE_TR` rising edge.
- **Transaction period** with continuous pending requests: 2+PULSE_W+GAP_W cycles, which is 10 with defaults.
- `BUSY` is registered and rises at the grant edge. It falls at the edge that leaves LOW.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `LED_METER_SCHED_PRIO0_EN`.
- **Defined:** channel 0 has strict priority. At every grant decision, `pend[0]=1` grants channel 0 regardless of `last`. Other channels are still round-robin among themselves, with `last` updated only by non-zero grants.
- **Undefined:** pure round-robin across all NCH channels.

## Test plan
All scenarios use NCH=4, PULSE_W=4, GAP_W=4.

- **Reset values:** hold `RESET_n=0`, then release → `VALUE=12'h800`, `SAMPLE_TR=0`, `CH_SEL=0`, `OVR=0`, `BUSY=0`.
- **Single request:** `IN_VALID[2]` with 12'hA55 → `VALUE=12'hA55` and `CH_SEL=2` one cycle before `SAMPLE_TR` rises; `SAMPLE_TR` is high 4 cycles, then low ≥4 cycles.
- **Round-robin order:**
  - Stimulus: all four channels strobe in one cycle with 12'h100/200/300/400.
  - Grant order without the macro: 0,1,2,3, with rising edges spaced 10 cycles apart.
  - Grant order with `LED_METER_SCHED_PRIO0_EN` and ch0 re-strobed during the ch1 transaction: 0,1,0,2,3.
- **Overrun:** ch1 strobes 12'h111 then 12'h222 while the FSM is busy on ch0 → `OVR[1]=1` and ch1's grant presents 12'h222. `OVR_CLR` clears the flag; `OVR_CLR` coincident with a new ch1 overrun leaves `OVR[1]=1`.
- **ENABLE low:** drop `ENABLE` during HIGH → the pulse completes its full 4 cycles, then no further grants. Restore `ENABLE` → the pending channel is granted on the next edge.
- **Reset mid-pulse:** assert `RESET_n` during HIGH → `SAMPLE_TR=0` asynchronously and all `pend` bits are cleared. After release, no transaction occurs without new strobes.

Source files
------------

// File: rtl/led_meter_sched.sv
// led_meter_sched: round-robin scheduler that shares one LED level-meter
// datapath among NCH 12-bit offset-binary sources (zero = 12'h800).
// Each source has a one-deep holding register. The scheduler grants one
// pending source at a time, presents its sample on VALUE, and then issues a
// SAMPLE_TR strobe. The strobe sequence is one SETUP cycle, PULSE_W cycles
// high and GAP_W cycles low.
//
// Optional feature: define LED_METER_SCHED_PRIO0_EN to give channel 0
// strict priority. The other channels stay round-robin among themselves.
//
// Ports:
//   CLK, RESET_n      clock, async active-low reset
//   IN_VALID[NCH]     per-channel sample strobe
//   IN_DATA[12*NCH]   channel k at [12k+11:12k]
//   ENABLE            permits new grants
//   OVR_CLR           clears all OVR flags
//   VALUE[12]         sample presented to the meter
//   SAMPLE_TR         meter capture strobe (rising edge)
//   CH_SEL[3]         channel owning VALUE
//   OVR[NCH]          sticky overrun flags
//   BUSY              high outside IDLE

// One channel: holding register, pending flag and sticky overrun flag.
module led_meter_chan (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    input  logic        consume,
    input  logic        ovr_clr,
    output logic [11:0] hold,
    output logic        pend,
    output logic        ovr
);
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            hold <= 12'h800;
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            // A new capture that coincides with a grant keeps pend set.
            // The grant reads the old hold value at this same edge.
            if (in_valid) begin
                hold <= in_data;
                pend <= 1'b1;
            end else if (consume) begin
                pend <= 1'b0;
            end
            // Setting the flag takes precedence over clearing it.
            if (in_valid && pend && !consume)
                ovr <= 1'b1;
            else if (ovr_clr)
                ovr <= 1'b0;
        end
    end
endmodule

module led_meter_sched #(
    parameter int NCH     = 4,
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 4
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic [NCH-1:0]    IN_VALID,
    input  logic [12*NCH-1:0] IN_DATA,
    input  logic              ENABLE,
    input  logic              OVR_CLR,
    output logic [11:0]       VALUE,
    output logic              SAMPLE_TR,
    output logic [2:0]        CH_SEL,
    output logic [NCH-1:0]    OVR,
    output logic              BUSY
);
    localparam int LW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NCH-1:0]  pend, req, consume;
    logic [11:0]     hold [NCH];
    logic [LW-1:0]   last, gnt;
    logic            found, fire;
    int              idx;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign consume[k] = fire && (gnt == LW'(k));
        led_meter_chan u_ch (
            .CLK      (CLK),
            .RESET_n  (RESET_n),
            .in_valid (IN_VALID[k]),
            .in_data  (IN_DATA[12*k +: 12]),
            .consume  (consume[k]),
            .ovr_clr  (OVR_CLR),
            .hold     (hold[k]),
            .pend     (pend[k]),
            .ovr      (OVR[k])
        );
    end

    // Search upward from last+1 (mod NCH) for the first pending channel.
    always_comb begin
        req   = pend;
`ifdef LED_METER_SCHED_PRIO0_EN
        req[0] = 1'b0;
`endif
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last) + i) % NCH;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = LW'(idx);
            end
        end
`ifdef LED_METER_SCHED_PRIO0_EN
        if (pend[0]) begin
            found = 1'b1;
            gnt   = '0;
        end
`endif
    end

    assign fire = (state == IDLE) && ENABLE && found;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:  if (fire) state_nxt = SETUP;
            SETUP: begin
                state_nxt = HIGH;
                cnt_nxt   = '0;
            end
            HIGH: begin
                if (cnt == CW'(PULSE_W - 1)) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOW: begin
                if (cnt == CW'(GAP_W - 1)) state_nxt = IDLE;
                else                       cnt_nxt   = cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are registered from the next state. As a result, SAMPLE_TR
    // and BUSY change on the same edge as the state they reflect.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            VALUE     <= 12'h800;
            CH_SEL    <= 3'd0;
            SAMPLE_TR <= 1'b0;
            BUSY      <= 1'b0;
            last      <= LW'(NCH - 1);
        end else begin
            SAMPLE_TR <= (state_nxt == HIGH);
            BUSY      <= (state_nxt != IDLE);
            if (fire) begin
                VALUE  <= hold[gnt];
                CH_SEL <= 3'(gnt);
`ifdef LED_METER_SCHED_PRIO0_EN
                if (gnt != '0) last <= gnt;
`else
                last <= gnt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_led_meter_sched.sv
module tb_led_meter_sched;
    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic [3:0]  IN_VALID = '0;
    logic [47:0] IN_DATA = '0;
    logic        ENABLE = 1'b1;
    logic        OVR_CLR = 1'b0;
    logic [11:0] VALUE;
    logic        SAMPLE_TR;
    logic [2:0]  CH_SEL;
    logic [3:0]  OVR;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    led_meter_sched #(.NCH(4), .PULSE_W(4), .GAP_W(4)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .ENABLE(ENABLE), .OVR_CLR(OVR_CLR), .VALUE(VALUE), .SAMPLE_TR(SAMPLE_TR),
        .CH_SEL(CH_SEL), .OVR(OVR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives the strobe for one cycle and returns at the next negedge.
    task automatic strobe(input logic [3:0] m, input logic [47:0] d);
        IN_VALID = m;
        IN_DATA  = d;
        @(negedge CLK);
        IN_VALID = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_n = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    // Waits for the next rising edge of SAMPLE_TR and samples CH_SEL, VALUE and the cycle count there.
    task automatic wait_rise(output int ch, output int val, output int t);
        logic p;
        int   n;
        bit   done;
        p = SAMPLE_TR; n = 0; done = 0; ch = -1; val = -1; t = -1;
        while (!done && n < 60) begin
            @(negedge CLK);
            n++;
            if (SAMPLE_TR && !p) begin
                done = 1; ch = int'(CH_SEL); val = int'(VALUE); t = cyc;
            end
            p = SAMPLE_TR;
        end
        if (!done) chk("rise_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) chk("idle_timeout", 0, 1);
    endtask

    // Entered at the first negedge with SAMPLE_TR high.
    task automatic measure_pulse(output int hi, output int lo);
        hi = 0; lo = 0;
        while (SAMPLE_TR && hi < 20) begin
            hi++;
            @(negedge CLK);
        end
        while (BUSY && !SAMPLE_TR && lo < 20) begin
            lo++;
            @(negedge CLK);
        end
    endtask

    int ch, val, t, hi, lo, n_busy;
    int tr_t [4];

    initial begin
        // Check the reset values.
        repeat (3) @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
        chk("rst_value", int'(VALUE), 'h800);
        chk("rst_tr", int'(SAMPLE_TR), 0);
        chk("rst_chsel", int'(CH_SEL), 0);
        chk("rst_ovr", int'(OVR), 0);
        chk("rst_busy", int'(BUSY), 0);

        // A single request on channel 2.
        strobe(4'b0100, {12'h0, 12'hA55, 12'h0, 12'h0});
        chk("single_busy_pre", int'(BUSY), 0);
        @(negedge CLK);
        chk("single_value", int'(VALUE), 'hA55);
        chk("single_chsel", int'(CH_SEL), 2);
        chk("single_busy", int'(BUSY), 1);
        chk("single_setup_tr", int'(SAMPLE_TR), 0);
        @(negedge CLK);
        chk("single_tr_rise", int'(SAMPLE_TR), 1);
        measure_pulse(hi, lo);
        chk("single_high_w", hi, 4);
        chk("single_low_w", lo, 4);

        // Round-robin order from reset, with all four channels strobed together.
        do_reset();
        strobe(4'b1111, {12'h400, 12'h300, 12'h200, 12'h100});
        for (int i = 0; i < 4; i++) begin
            wait_rise(ch, val, t);
            tr_t[i] = t;
            chk($sformatf("rr_ch%0d", i), ch, i);
            chk($sformatf("rr_val%0d", i), val, (i + 1) * 'h100);
            if (i > 0) chk($sformatf("rr_period%0d", i), tr_t[i] - tr_t[i-1], 10);
        end
        wait_idle();

        // Overrun: channel 1 is strobed twice while channel 0 is in service.
        @(negedge CLK);
        strobe(4'b0001, {36'h0, 12'h0AA});
        strobe(4'b0010, {24'h0, 12'h111, 12'h0});
        strobe(4'b0010, {24'h0, 12'h222, 12'h0});
        chk("ovr_set", int'(OVR), 'b0010);
        wait_rise(ch, val, t);
        chk("ovr_grant_ch", ch, 1);
        chk("ovr_grant_val", val, 'h222);
        wait_idle();
        OVR_CLR = 1'b1;
        @(negedge CLK);
        OVR_CLR = 1'b0;
        chk("ovr_clr", int'(OVR), 0);
        // An OVR_CLR that coincides with a new overrun leaves the flag set.
        ENABLE = 1'b0;
        strobe(4'b0010, {24'h0, 12'h333, 12'h0});
        OVR_CLR = 1'b1;
        strobe(4'b0010, {24'h0, 12'h444, 12'h0});
        OVR_CLR = 1'b0;
        chk("ovr_clr_vs_set", int'(OVR), 'b0010);
        chk("dis_no_grant", int'(BUSY), 0);
        ENABLE = 1'b1;
        @(negedge CLK);
        chk("en_grant_busy", int'(BUSY), 1);
        chk("en_grant_ch", int'(CH_SEL), 1);
        chk("en_grant_val", int'(VALUE), 'h444);
        wait_idle();

        // ENABLE drops during HIGH. last is 1 here, so channel 2 is granted before channel 0.
        @(negedge CLK);
        strobe(4'b0101, {12'h0, 12'h5A2, 12'h0, 12'h5A0});
        wait_rise(ch, val, t);
        chk("en_rr_ch", ch, 2);
        ENABLE = 1'b0;
        measure_pulse(hi, lo);
        chk("en_high_w", hi, 4);
        chk("en_low_w", lo, 4);
        n_busy = 0;
        repeat (20) begin
            @(negedge CLK);
            if (BUSY) n_busy++;
        end
        chk("en_parked", n_busy, 0);
        ENABLE = 1'b1;
        @(negedge CLK);
        chk("en_restore_busy", int'(BUSY), 1);
        chk("en_restore_ch", int'(CH_SEL), 0);
        chk("en_restore_val", int'(VALUE), 'h5A0);

        // Reset mid-pulse, with channels 1 and 3 pending.
        strobe(4'b1010, {12'h777, 12'h0, 12'h666, 12'h0});
        chk("rstm_pre_tr", int'(SAMPLE_TR), 1);
        #2 RESET_n = 1'b0;
        #1;
        chk("rstm_tr", int'(SAMPLE_TR), 0);
        chk("rstm_busy", int'(BUSY), 0);
        chk("rstm_value", int'(VALUE), 'h800);
        @(negedge CLK);
        RESET_n = 1'b1;
        n_busy = 0;
        repeat (30) begin
            @(negedge CLK);
            if (BUSY || SAMPLE_TR) n_busy++;
        end
        chk("rstm_no_txn", n_busy, 0);
        chk("rstm_ovr", int'(OVR), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
